input_port_arbiter: RTL and testbench

Round-robin arbiter that shares the CPU's single 8-bit input port register among several byte sources, such as switches, a UART receiver and a keypad scanner. It picks one requesting source and drives the port register's data and write-enable. It then holds off all other sources until the CPU signals that it has consumed the byte. The block sits between the peripheral sources and the input port register; the CPU-side read decode drives `Consumed`.

---
 rtl/input_port_arbiter.sv | 134 +++++++++++++
 tb/tb_input_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/input_port_arbiter.sv
// Round-robin arbiter sharing one 8-bit CPU input port register among several
// byte sources; one byte is in flight until the CPU reports it consumed.
module input_port_arbiter #(
  parameter int WIDTH_DATA_LENGTH = 8,
  parameter int NUM_SOURCES       = 4,
  parameter int SRC_BITS          = 2
) (
  input  logic                                     Clk,
  input  logic                                     Rst,
  input  logic [NUM_SOURCES-1:0]                   Req,
  input  logic [NUM_SOURCES*WIDTH_DATA_LENGTH-1:0] Data,
  input  logic                                     Consumed,
  output logic [NUM_SOURCES-1:0]                   Grant,
  output logic [WIDTH_DATA_LENGTH-1:0]             PortInput,
  output logic                                     PortWrite,
  output logic [SRC_BITS-1:0]                      SrcId,
  output logic                                     Full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                       state_r;
  logic [SRC_BITS-1:0]          ptr_r;
  logic [SRC_BITS-1:0]          winner_s;
  logic                         found_s;
  logic [SRC_BITS-1:0]          ptr_next_s;
  logic [WIDTH_DATA_LENGTH-1:0] data_arr_s [NUM_SOURCES];

  // Scans from ptr upward with wrap; the loop runs from the farthest offset
  // down so the nearest requester is the last one written.
  function automatic logic [SRC_BITS:0] pick_winner(
    input logic [NUM_SOURCES-1:0] req,
    input logic [SRC_BITS-1:0]    ptr
  );
    logic [SRC_BITS:0]   res;
    logic [SRC_BITS:0]   sum;
    logic [SRC_BITS-1:0] idx;
    res = {1'b0, {SRC_BITS{1'b0}}};
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (SRC_BITS+1)'(k);
      if (sum >= (SRC_BITS+1)'(NUM_SOURCES)) begin
        sum = sum - (SRC_BITS+1)'(NUM_SOURCES);
      end else begin
        sum = sum;
      end
      idx = sum[SRC_BITS-1:0];
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Unpack the flat source data bus into one byte per source.
  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      data_arr_s[i] = Data[i*WIDTH_DATA_LENGTH +: WIDTH_DATA_LENGTH];
    end
  end

  // Winner selection and the pointer value that follows it.
  always_comb begin
    winner_s   = {SRC_BITS{1'b0}};
    found_s    = 1'b0;
    ptr_next_s = {SRC_BITS{1'b0}};
    {found_s, winner_s} = pick_winner(Req, ptr_r);
    if (winner_s == SRC_BITS'(NUM_SOURCES - 1)) begin
      ptr_next_s = {SRC_BITS{1'b0}};
    end else begin
      ptr_next_s = winner_s + SRC_BITS'(1);
    end
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r   <= IDLE;
      ptr_r     <= {SRC_BITS{1'b0}};
      Grant     <= {NUM_SOURCES{1'b0}};
      PortWrite <= 1'b0;
      PortInput <= {WIDTH_DATA_LENGTH{1'b0}};
      SrcId     <= {SRC_BITS{1'b0}};
      Full      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r   <= GRANT;
            Grant     <= {{(NUM_SOURCES-1){1'b0}}, 1'b1} << winner_s;
            PortWrite <= 1'b1;
            PortInput <= data_arr_s[winner_s];
            SrcId     <= winner_s;
            Full      <= 1'b1;
            ptr_r     <= ptr_next_s;
          end else begin
            Grant     <= {NUM_SOURCES{1'b0}};
            PortWrite <= 1'b0;
          end
        end
        GRANT: begin
          state_r   <= HOLD;
          Grant     <= {NUM_SOURCES{1'b0}};
          PortWrite <= 1'b0;
          Full      <= 1'b1;
        end
        HOLD: begin
          Grant     <= {NUM_SOURCES{1'b0}};
          PortWrite <= 1'b0;
          // Requests are deliberately not looked at here; they wait for IDLE.
          if (Consumed) begin
            state_r <= IDLE;
            Full    <= 1'b0;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r   <= IDLE;
          ptr_r     <= {SRC_BITS{1'b0}};
          Grant     <= {NUM_SOURCES{1'b0}};
          PortWrite <= 1'b0;
          Full      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_arbiter.sv
// Directed vector table plus hand-written sequences for blocking and
// mid-transfer reset of input_port_arbiter.
module tb_input_port_arbiter;

  logic        Clk;
  logic        Rst;
  logic [3:0]  Req;
  logic [31:0] Data;
  logic        Consumed;
  logic [3:0]  Grant;
  logic [7:0]  PortInput;
  logic        PortWrite;
  logic [1:0]  SrcId;
  logic        Full;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       cons;
    logic [3:0] g;
    logic       pw;
    logic [7:0] pi;
    logic [1:0] src;
    logic       full;
  } vec_t;

  vec_t vq[$];

  input_port_arbiter #(
    .WIDTH_DATA_LENGTH(8),
    .NUM_SOURCES(4),
    .SRC_BITS(2)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Req(Req),
    .Data(Data),
    .Consumed(Consumed),
    .Grant(Grant),
    .PortInput(PortInput),
    .PortWrite(PortWrite),
    .SrcId(SrcId),
    .Full(Full)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic c);
    Rst      = r;
    Req      = q;
    Consumed = c;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] g, input logic pw,
                            input logic [7:0] pi, input logic [1:0] src, input logic f);
    chk({nm, ".grant"}, 32'(Grant), 32'(g));
    chk({nm, ".portwrite"}, 32'(PortWrite), 32'(pw));
    chk({nm, ".portinput"}, 32'(PortInput), 32'(pi));
    chk({nm, ".srcid"}, 32'(SrcId), 32'(src));
    chk({nm, ".full"}, 32'(Full), 32'(f));
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    // src3=3C, src2=A5, src1=5A, src0=11
    Data     = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    drive(1'b0, 4'hF, 1'b0);

    // rst, req, cons -> grant, pw, portinput, srcid, full
    vq.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0});
    vq.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0});
    vq.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0});
    // single transfer from source 2
    vq.push_back('{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1});
    vq.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1});
    vq.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1});
    vq.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0});
    vq.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0});
    // wrap and skip: ptr=3, req 0011 -> source 0 then source 1
    vq.push_back('{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1});
    vq.push_back('{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b1});
    // Consumed and Req together in HOLD: only Consumed taken
    vq.push_back('{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b0});
    vq.push_back('{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h5A, 2'd1, 1'b1});
    vq.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd1, 1'b1});
    vq.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd1, 1'b0});
    // fairness after a fresh reset, all requesting, Consumed held high
    vq.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b1});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b0});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h5A, 2'd1, 1'b1});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd1, 1'b1});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd1, 1'b0});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3, 1'b1});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h3C, 2'd3, 1'b1});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h3C, 2'd3, 1'b0});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b1});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b0});
    vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h5A, 2'd1, 1'b1});

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].req, vq[i].cons);
      step();
      expect_out($sformatf("vec%0d", i), vq[i].g, vq[i].pw, vq[i].pi, vq[i].src, vq[i].full);
    end

    // Blocking: source 1 granted, source 3 requests while Consumed stays low.
    drive(1'b1, 4'b1000, 1'b0);
    step();
    expect_out("block_enter", 4'b0000, 1'b0, 8'h5A, 2'd1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out($sformatf("block%0d", i), 4'b0000, 1'b0, 8'h5A, 2'd1, 1'b1);
    end
    drive(1'b1, 4'b1000, 1'b1);
    step();
    expect_out("block_release", 4'b0000, 1'b0, 8'h5A, 2'd1, 1'b0);
    drive(1'b1, 4'b1000, 1'b0);
    step();
    expect_out("block_grant3", 4'b1000, 1'b1, 8'h3C, 2'd3, 1'b1);

    // Reset while in GRANT, then a spurious Consumed.
    drive(1'b0, 4'b0000, 1'b0);
    step();
    expect_out("rst_grant", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    drive(1'b1, 4'b0000, 1'b1);
    step();
    expect_out("rst_grant_spur", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);

    // Grant to source 1 (ptr becomes 2), reset in HOLD, ptr must return to 0.
    drive(1'b1, 4'b0110, 1'b0);
    step();
    expect_out("pre_hold_grant", 4'b0010, 1'b1, 8'h5A, 2'd1, 1'b1);
    drive(1'b1, 4'b0000, 1'b0);
    step();
    expect_out("pre_hold", 4'b0000, 1'b0, 8'h5A, 2'd1, 1'b1);
    drive(1'b0, 4'b0000, 1'b0);
    step();
    expect_out("rst_hold", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    drive(1'b1, 4'b0000, 1'b1);
    step();
    expect_out("rst_hold_spur", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    drive(1'b1, 4'b0110, 1'b0);
    step();
    expect_out("ptr_after_rst", 4'b0010, 1'b1, 8'h5A, 2'd1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
